// File: rtl/comp32_pkg.sv
// Shared types and constants for the comp32_arb arbitrated comparator.
// Optional equality output is enabled by defining COMP32_ARB_EQ_EN.
package comp32_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp32_gt_core.sv
// Combinational unsigned W-bit comparator shared by all requesters.
// The eq output exists only when COMP32_ARB_EQ_EN is defined.
module comp32_gt_core #(
    parameter int W = comp32_pkg::DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef COMP32_ARB_EQ_EN
    output logic         eq,
`endif
    output logic         gt
);

    assign gt = (a > b);
`ifdef COMP32_ARB_EQ_EN
    assign eq = (a == b);
`endif

endmodule

// File: rtl/comp32_arb.sv
// Round-robin arbiter in front of one shared unsigned comparator (IDLE/CMP/RESP).
// Defining COMP32_ARB_EQ_EN adds a registered rsp_eq output.
module comp32_arb
    import comp32_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NREQ)-1:0]   rsp_id,
`ifdef COMP32_ARB_EQ_EN
    output logic                    rsp_eq,
`endif
    output logic                    rsp_gt
);

    localparam int IDW = id_w(NREQ);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   lat_a;
    logic [W-1:0]   lat_b;
    logic [W-1:0]   a_arr [NREQ];
    logic [W-1:0]   b_arr [NREQ];
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_id;
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           accept;
    logic           core_gt;
`ifdef COMP32_ARB_EQ_EN
    logic           core_eq;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*W +: W];
            assign b_arr[gi] = req_b[gi*W +: W];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping from NREQ-1 back to 0.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr} + (IDW+1)'(off);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    comp32_gt_core #(.W(W)) u_core (
        .a  (lat_a),
        .b  (lat_b),
`ifdef COMP32_ARB_EQ_EN
        .eq (core_eq),
`endif
        .gt (core_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_id    <= '0;
`ifdef COMP32_ARB_EQ_EN
            rsp_eq    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_a  <= a_arr[grant_id];
                        lat_b  <= b_arr[grant_id];
                        rsp_id <= grant_id;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    rsp_gt    <= core_gt;
`ifdef COMP32_ARB_EQ_EN
                    rsp_eq    <= core_eq;
`endif
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp32_arb.sv
// Directed self-checking bench for comp32_arb (NREQ=4, W=32).
// Define COMP32_ARB_EQ_EN to also check rsp_eq.
module tb_comp32_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic         rsp_gt;
`ifdef COMP32_ARB_EQ_EN
    logic         rsp_eq;
`endif

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    comp32_arb #(.NREQ(4), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef COMP32_ARB_EQ_EN
        .rsp_eq    (rsp_eq),
`endif
        .rsp_gt    (rsp_gt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for any req_ready bit; ok=0 on timeout.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        #1;
        for (int n = 0; n < 8; n++) begin
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // One full transaction with rsp_ready=1 from an otherwise idle block.
    task automatic run_one(input string name, input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic gt, input logic eq);
        bit ok;
        logic [3:0] exp_rdy;
        exp_rdy = 4'(1 << i);
        set_ops(i, a, b);
        rsp_ready    = 1'b1;
        req_valid[i] = 1'b1;
        wait_grant(ok);
        nvec++;
        if (!ok || req_ready !== exp_rdy) begin
            nerr++;
            $display("FAIL %s grant: req_ready=%b required %b", name, req_ready, exp_rdy);
        end
        tick();
        req_valid[i] = 1'b0;
        #1;
        nvec++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            nerr++;
            $display("FAIL %s cmp: rsp_valid=%b req_ready=%b required 0 0000", name, rsp_valid, req_ready);
        end
        tick();
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(i) || rsp_gt !== gt) begin
            nerr++;
            $display("FAIL %s resp: valid=%b id=%0d gt=%b required 1 %0d %b", name, rsp_valid, rsp_id, rsp_gt, i, gt);
        end
`ifdef COMP32_ARB_EQ_EN
        nvec++;
        if (rsp_eq !== eq) begin
            nerr++;
            $display("FAIL %s eq: rsp_eq=%b required %b", name, rsp_eq, eq);
        end
`endif
        tick();
        nvec++;
        if (rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s drop: rsp_valid=%b required 0", name, rsp_valid);
        end
        $display("txn %s: id=%0d a=%h b=%h gt=%b eq=%b", name, i, a, b, gt, eq);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0001;
        tick();
        tick();
        nvec++;
        if (rsp_valid !== 1'b0 || rsp_gt !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_state: valid=%b gt=%b id=%0d rdy=%b required 0 0 0 0000",
                     rsp_valid, rsp_gt, rsp_id, req_ready);
        end
`ifdef COMP32_ARB_EQ_EN
        nvec++;
        if (rsp_eq !== 1'b0) begin
            nerr++;
            $display("FAIL reset_eq: rsp_eq=%b required 0", rsp_eq);
        end
`endif
        rst = 1'b0;
        #1;
        nvec++;
        if (req_ready !== 4'b0001) begin
            nerr++;
            $display("FAIL reset_release: req_ready=%b required 0001", req_ready);
        end
        req_valid = '0;
        $display("txn reset: checked");
    endtask

    task automatic test_single();
        run_one("single", 0, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0);
    endtask

    task automatic test_edges();
        run_one("zero_lt_one", 1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_one("unsigned_max", 2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_one("equal", 3, 32'h0000_000E, 32'h0000_000E, 1'b0, 1'b1);
    endtask

    task automatic test_contention();
        bit ok;
        int last;
        int exp_id;
        logic [3:0] exp_rdy;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd2);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            exp_id  = k % 4;
            exp_rdy = 4'(1 << exp_id);
            wait_grant(ok);
            nvec++;
            if (!ok || req_ready !== exp_rdy) begin
                nerr++;
                $display("FAIL contention_grant%0d: req_ready=%b required %b", k, req_ready, exp_rdy);
            end
            if (k > 0) begin
                nvec++;
                if (cyc - last != 3) begin
                    nerr++;
                    $display("FAIL contention_rate%0d: spacing=%0d required 3", k, cyc - last);
                end
            end
            last = cyc;
            tick();
            tick();
            nvec++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_gt !== (exp_id == 3)) begin
                nerr++;
                $display("FAIL contention_rsp%0d: valid=%b id=%0d gt=%b required 1 %0d %b",
                         k, rsp_valid, rsp_id, rsp_gt, exp_id, exp_id == 3);
            end
            $display("txn contention: order %0d id=%0d gt=%b", k, rsp_id, rsp_gt);
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [1:0] hold_id;
        logic       hold_gt;
        set_ops(0, 32'd5, 32'd9);
        set_ops(2, 32'h8000_0000, 32'h7FFF_FFFF);
        rsp_ready    = 1'b0;
        req_valid[0] = 1'b1;
        wait_grant(ok);
        nvec++;
        if (!ok || req_ready !== 4'b0001) begin
            nerr++;
            $display("FAIL bp_grant0: req_ready=%b required 0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b1;
        tick();
        hold_id = rsp_id;
        hold_gt = rsp_gt;
        nvec++;
        if (hold_id !== 2'd0 || hold_gt !== 1'b0) begin
            nerr++;
            $display("FAIL bp_first: id=%0d gt=%b required 0 0", hold_id, hold_gt);
        end
        for (int n = 0; n < 5; n++) begin
            nvec++;
            if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_gt !== hold_gt || req_ready !== 4'b0000) begin
                nerr++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d gt=%b rdy=%b required 1 0 0 0000",
                         n, rsp_valid, rsp_id, rsp_gt, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        nvec++;
        if (req_ready !== 4'b0000) begin
            nerr++;
            $display("FAIL bp_release_edge: req_ready=%b required 0000", req_ready);
        end
        tick();
        nvec++;
        if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL bp_next_grant: req_ready=%b rsp_valid=%b required 0100 0", req_ready, rsp_valid);
        end
        tick();
        req_valid[2] = 1'b0;
        tick();
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_gt !== 1'b1) begin
            nerr++;
            $display("FAIL bp_rsp2: valid=%b id=%0d gt=%b required 1 2 1", rsp_valid, rsp_id, rsp_gt);
        end
        $display("txn back_pressure: held 5 cycles then id=%0d gt=%b", rsp_id, rsp_gt);
        tick();
    endtask

    task automatic test_wrap();
        // Previous transaction served requester 2, leaving ptr=3.
        set_ops(1, 32'd1, 32'd1);
        set_ops(3, 32'd10, 32'd3);
        req_valid = 4'b1010;
        #1;
        nvec++;
        if (req_ready !== 4'b1000) begin
            nerr++;
            $display("FAIL wrap_first: req_ready=%b required 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        tick();
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_gt !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_rsp3: valid=%b id=%0d gt=%b required 1 3 1", rsp_valid, rsp_id, rsp_gt);
        end
        tick();
        nvec++;
        if (req_ready !== 4'b0010) begin
            nerr++;
            $display("FAIL wrap_second: req_ready=%b required 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        tick();
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_gt !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_rsp1: valid=%b id=%0d gt=%b required 1 1 0", rsp_valid, rsp_id, rsp_gt);
        end
        $display("txn wrap: 3 then 1");
        tick();
    endtask

    task automatic test_reset_in_cmp();
        bit ok;
        // ptr is 2 here, so a surviving pointer would grant 3 before 0.
        set_ops(1, 32'd7, 32'd1);
        req_valid[1] = 1'b1;
        wait_grant(ok);
        nvec++;
        if (!ok || req_ready !== 4'b0010) begin
            nerr++;
            $display("FAIL rcmp_grant: req_ready=%b required 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        nvec++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_id !== 2'd0) begin
            nerr++;
            $display("FAIL rcmp_during: valid=%b rdy=%b id=%0d required 0 0000 0", rsp_valid, req_ready, rsp_id);
        end
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            nvec++;
            if (rsp_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rcmp_norsp%0d: rsp_valid=%b required 0", n, rsp_valid);
            end
            tick();
        end
        set_ops(0, 32'h1234_5678, 32'h1234_5679);
        set_ops(3, 32'd9, 32'd1);
        req_valid = 4'b1001;
        #1;
        nvec++;
        if (req_ready !== 4'b0001) begin
            nerr++;
            $display("FAIL rcmp_ptr: req_ready=%b required 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_gt !== 1'b0) begin
            nerr++;
            $display("FAIL rcmp_rsp: valid=%b id=%0d gt=%b required 1 0 0", rsp_valid, rsp_id, rsp_gt);
        end
        $display("txn reset_in_cmp: discarded, next id=%0d", rsp_id);
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_edges();
        test_contention();
        test_back_pressure();
        test_wrap();
        test_reset_in_cmp();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/comp32_arb.md
COMP32_ARB -- requirements
Module: comp32_arb

Interface
- REQ-001 Parameter NREQ, default 4, number of requesters sharing the comparator.
- REQ-002 Parameter W, default 32, operand width in bits.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 req_valid  input  NREQ  per-requester compare request.
- REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high at a time.
- REQ-007 req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- REQ-008 req_b  input  NREQ*W  packed operand B; same packing as req_a.
- REQ-009 rsp_valid  output  1  result available.
- REQ-010 rsp_ready  input  1  consumer accepts the result.
- REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
- REQ-012 rsp_gt  output  1  1 when A > B, unsigned.

Function
- REQ-013 The FSM SHALL have states IDLE, CMP and RESP.
- REQ-014 IDLE: the grant SHALL be the first asserted req_valid at or after index ptr, searching round-robin with wrap from NREQ-1 to 0.
- REQ-015 IDLE: req_ready SHALL be combinational, one-hot on the granted index, and all-zero when no req_valid is high.
- REQ-016 A handshake (req_valid[i] & req_ready[i]) SHALL latch req_a/req_b slice i and index i, then move to CMP.
- REQ-017 CMP: the latched operands SHALL drive the shared comparator; its result SHALL be registered into rsp_gt, and the FSM SHALL move to RESP.
- REQ-018 RESP: rsp_valid SHALL be 1, and rsp_gt and rsp_id SHALL be held stable until rsp_ready is 1.
- REQ-019 RESP with rsp_ready=1: the FSM SHALL set ptr to (rsp_id+1) mod NREQ and return to IDLE.
- REQ-020 Latency: rsp_valid SHALL rise exactly 2 cycles after the accepting edge; maximum throughput SHALL be one compare per 3 cycles.
- REQ-021 req_ready SHALL be all-zero in CMP and RESP; requesters SHALL hold req_valid and their operands until accepted.
- REQ-022 A requester that drops req_valid before acceptance SHALL have no effect.
- REQ-023 Comparison SHALL be unsigned across the full W bits; A == B SHALL give rsp_gt=0.

Reset
- REQ-024 While rst=1, the block SHALL set state=IDLE, ptr=0, rsp_valid=0, rsp_gt=0, rsp_id=0, latched operands=0 and req_ready=0.
- REQ-025 Asserting rst mid-operation (CMP or RESP) SHALL discard the in-flight compare without producing a response.
- REQ-026 On the first edge after rst deasserts, the block SHALL be able to accept a request.

Configuration
- REQ-027 Macro COMP32_ARB_EQ_EN SHALL control an extra output rsp_eq (output, 1 bit): 1 when A == B, registered and held with the same timing as rsp_gt.
- REQ-028 With COMP32_ARB_EQ_EN defined, rsp_eq SHALL reset to 0.
- REQ-029 Without COMP32_ARB_EQ_EN, the rsp_eq port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
- REQ-030 Shared package comp32_pkg SHALL hold the FSM state enum (IDLE/CMP/RESP), the default W and NREQ constants, and the id-width function.
- REQ-031 The comparator SHALL be a separate combinational sub-module, comp32_gt_core (W-bit a, b in; gt out, plus eq when COMP32_ARB_EQ_EN is defined), instantiated exactly once.

Verification
- REQ-032 Single request: req 0 with a=0x00000003, b=0x00000002, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_gt=1.
- REQ-033 Edge values: a=0x00000000, b=0x00000001 -> rsp_gt=0; a=0xFFFFFFFF, b=0x7FFFFFFF -> rsp_gt=1 (unsigned); a=b=0x0000000E -> rsp_gt=0, and rsp_eq=1 when EQ_EN is defined.
- REQ-034 Contention: all 4 requesters valid from reset, rsp_ready=1 -> service order 0,1,2,3,0; one response every 3 cycles.
- REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_gt stable; req_ready all-zero; a request from requester 2 is not accepted until 1 cycle after rsp_ready=1.
- REQ-036 Pointer wrap: ptr=3, requesters 1 and 3 valid -> 3 granted first, then 1.
- REQ-037 Reset in CMP: assert rst for 1 cycle after accept -> no rsp_valid, ptr=0, and the next request is accepted normally.
